fifo_multi_channel: RTL and testbench

- Single-clock, multi-channel FIFO buffer with NUM_CH independent queues of DEPTH entries each, held in one banked storage array.
- Successor to the single-queue memory block. Adds per-channel pointers, occupancy counts, full/empty/almost-full flags, a registered read with a valid strobe, and sticky overflow/underflow error reporting.
- Sits between a channelised producer (e.g. packet demux) and a scheduler that drains channels by index.

---
 rtl/fifo_multi_channel.sv | 140 ++++++++++++++
 tb/tb_fifo_multi_channel.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_multi_channel.sv
// Multi-channel FIFO: NUM_CH independent queues of DEPTH words sharing one banked
// storage array, with per-channel occupancy flags, a registered read port and
// sticky overflow/underflow error reporting.
module fifo_multi_channel #(
    parameter int unsigned DATA_SIZE = 8,
    parameter int unsigned ADDR_SIZE = 4,
    parameter int unsigned NUM_CH    = 4,
    parameter int unsigned AF_MARGIN = 2,
    localparam int unsigned CH_W     = $clog2(NUM_CH),
    localparam int unsigned PW       = ADDR_SIZE + 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   wr_en,
    input  logic [CH_W-1:0]        wr_ch,
    input  logic [DATA_SIZE-1:0]   wr_data,
    input  logic                   rd_en,
    input  logic [CH_W-1:0]        rd_ch,
    output logic [DATA_SIZE-1:0]   rd_data,
    output logic                   rd_valid,
    output logic [NUM_CH-1:0]      full,
    output logic [NUM_CH-1:0]      empty,
    output logic [NUM_CH-1:0]      almost_full,
    output logic [NUM_CH*PW-1:0]   count,
    output logic                   ovf_err,
    output logic                   udf_err,
    input  logic                   clr_err
);

    localparam int unsigned DEPTH     = 1 << ADDR_SIZE;
    localparam int unsigned MEM_WORDS = NUM_CH * DEPTH;
    localparam int unsigned IDX_W     = CH_W + ADDR_SIZE;

    localparam logic [PW-1:0] CntZero  = '0;
    localparam logic [PW-1:0] CntOne   = PW'(1);
    localparam logic [PW-1:0] CntFull  = PW'(DEPTH);
    localparam logic [PW-1:0] CntAfThr = PW'(DEPTH - AF_MARGIN);

    logic [DATA_SIZE-1:0] mem_q [MEM_WORDS];

    logic [PW-1:0] wr_ptr_q [NUM_CH];
    logic [PW-1:0] wr_ptr_d [NUM_CH];
    logic [PW-1:0] rd_ptr_q [NUM_CH];
    logic [PW-1:0] rd_ptr_d [NUM_CH];
    logic [PW-1:0] cnt_q    [NUM_CH];
    logic [PW-1:0] cnt_d    [NUM_CH];

    logic [DATA_SIZE-1:0] rd_data_q, rd_data_d;
    logic                 rd_valid_q, rd_valid_d;
    logic                 ovf_err_q, ovf_err_d;
    logic                 udf_err_q, udf_err_d;

    logic                 wr_ch_ok, rd_ch_ok;
    logic                 wr_acc, rd_acc;
    logic [NUM_CH-1:0]    wr_sel, rd_sel;
    logic [IDX_W-1:0]     wr_idx, rd_idx;

    // Per-channel flags straight from the registered counts.
    always_comb begin
        full        = '0;
        empty       = '0;
        almost_full = '0;
        count       = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            empty[i]           = (cnt_q[i] == CntZero);
            full[i]            = (cnt_q[i] == CntFull);
            almost_full[i]     = (cnt_q[i] >= CntAfThr);
            count[i*PW +: PW]  = cnt_q[i];
        end
    end

    // Acceptance decode; both sides judged against pre-edge flags.
    always_comb begin
        wr_ch_ok = (32'(wr_ch) < NUM_CH);
        rd_ch_ok = (32'(rd_ch) < NUM_CH);
        wr_acc   = wr_en && wr_ch_ok && !full[wr_ch];
        rd_acc   = rd_en && rd_ch_ok && !empty[rd_ch];
        wr_sel   = wr_acc ? (NUM_CH'(1) << wr_ch) : '0;
        rd_sel   = rd_acc ? (NUM_CH'(1) << rd_ch) : '0;
        wr_idx   = wr_acc ? {wr_ch, wr_ptr_q[wr_ch][ADDR_SIZE-1:0]} : '0;
        rd_idx   = rd_acc ? {rd_ch, rd_ptr_q[rd_ch][ADDR_SIZE-1:0]} : '0;
    end

    // Next-state for pointers, counts, read port and sticky errors.
    always_comb begin
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            wr_ptr_d[i] = wr_ptr_q[i];
            rd_ptr_d[i] = rd_ptr_q[i];
            cnt_d[i]    = cnt_q[i];
            if (wr_sel[i]) wr_ptr_d[i] = wr_ptr_q[i] + CntOne;
            if (rd_sel[i]) rd_ptr_d[i] = rd_ptr_q[i] + CntOne;
            if (wr_sel[i] && !rd_sel[i]) cnt_d[i] = cnt_q[i] + CntOne;
            if (rd_sel[i] && !wr_sel[i]) cnt_d[i] = cnt_q[i] - CntOne;
        end
        // Storage read sees pre-edge contents, so a same-cycle write never leaks through.
        rd_data_d  = rd_acc ? mem_q[rd_idx] : rd_data_q;
        rd_valid_d = rd_acc;
        // Clear first so a coinciding rejection wins.
        ovf_err_d  = clr_err ? 1'b0 : ovf_err_q;
        udf_err_d  = clr_err ? 1'b0 : udf_err_q;
        if (wr_en && !wr_acc) ovf_err_d = 1'b1;
        if (rd_en && !rd_acc) udf_err_d = 1'b1;
    end

    // Control state with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                wr_ptr_q[i] <= '0;
                rd_ptr_q[i] <= '0;
                cnt_q[i]    <= '0;
            end
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            ovf_err_q  <= 1'b0;
            udf_err_q  <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                wr_ptr_q[i] <= wr_ptr_d[i];
                rd_ptr_q[i] <= rd_ptr_d[i];
                cnt_q[i]    <= cnt_d[i];
            end
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            ovf_err_q  <= ovf_err_d;
            udf_err_q  <= udf_err_d;
        end
    end

    // Storage array; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (wr_acc) mem_q[wr_idx] <= wr_data;
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
    assign ovf_err  = ovf_err_q;
    assign udf_err  = udf_err_q;

endmodule

// File: tb/tb_fifo_multi_channel.sv
// Directed self-checking bench for fifo_multi_channel (default parameters).
module tb_fifo_multi_channel;

    localparam int unsigned DW = 8;
    localparam int unsigned AW = 4;
    localparam int unsigned NC = 4;
    localparam int unsigned PW = AW + 1;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            wr_en = 1'b0;
    logic [1:0]      wr_ch = '0;
    logic [DW-1:0]   wr_data = '0;
    logic            rd_en = 1'b0;
    logic [1:0]      rd_ch = '0;
    logic [DW-1:0]   rd_data;
    logic            rd_valid;
    logic [NC-1:0]   full, empty, almost_full;
    logic [NC*PW-1:0] count;
    logic            ovf_err, udf_err;
    logic            clr_err = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    fifo_multi_channel #(
        .DATA_SIZE (DW),
        .ADDR_SIZE (AW),
        .NUM_CH    (NC),
        .AF_MARGIN (2)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .wr_en       (wr_en),
        .wr_ch       (wr_ch),
        .wr_data     (wr_data),
        .rd_en       (rd_en),
        .rd_ch       (rd_ch),
        .rd_data     (rd_data),
        .rd_valid    (rd_valid),
        .full        (full),
        .empty       (empty),
        .almost_full (almost_full),
        .count       (count),
        .ovf_err     (ovf_err),
        .udf_err     (udf_err),
        .clr_err     (clr_err)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] cnt_of(input int ch);
        return 32'(count[ch*PW +: PW]);
    endfunction

    // Advance one edge; inputs change and outputs are sampled 1ns after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr_en = 1'b0; rd_en = 1'b0; clr_err = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        check_eq({tag, "_empty"}, 32'(empty), 32'hF);
        check_eq({tag, "_full"}, 32'(full), 32'h0);
        check_eq({tag, "_af"}, 32'(almost_full), 32'h0);
        check_eq({tag, "_count"}, 32'(count), 32'h0);
        check_eq({tag, "_rd_data"}, 32'(rd_data), 32'h0);
        check_eq({tag, "_rd_valid"}, 32'(rd_valid), 32'h0);
        check_eq({tag, "_ovf"}, 32'(ovf_err), 32'h0);
        check_eq({tag, "_udf"}, 32'(udf_err), 32'h0);
    endtask

    initial begin
        // Reset state
        #12;
        check_reset_state("rst");
        rst_n = 1'b1;
        step();

        // Basic write/read on ch1
        wr_en = 1'b1; wr_ch = 2'd1;
        wr_data = 8'h11; step();
        wr_data = 8'h22; step();
        wr_data = 8'h33; step();
        idle();
        check_eq("ch1_cnt3", cnt_of(1), 32'd3);
        check_eq("ch1_not_empty", 32'(empty[1]), 32'd0);
        rd_en = 1'b1; rd_ch = 2'd1;
        step();
        check_eq("rd0_valid", 32'(rd_valid), 32'd1);
        check_eq("rd0_data", 32'(rd_data), 32'h11);
        step();
        check_eq("rd1_valid", 32'(rd_valid), 32'd1);
        check_eq("rd1_data", 32'(rd_data), 32'h22);
        step();
        check_eq("rd2_valid", 32'(rd_valid), 32'd1);
        check_eq("rd2_data", 32'(rd_data), 32'h33);
        idle();
        step();
        check_eq("rd_idle_valid", 32'(rd_valid), 32'd0);
        check_eq("rd_idle_hold", 32'(rd_data), 32'h33);
        check_eq("ch1_empty", 32'(empty[1]), 32'd1);
        check_eq("ch1_udf_clean", 32'(udf_err), 32'd0);

        // Fill ch2 and overflow it
        wr_en = 1'b1; wr_ch = 2'd2;
        for (int i = 0; i < 16; i++) begin
            wr_data = 8'(8'hA0 + i);
            step();
            check_eq($sformatf("ch2_af_%0d", i + 1), 32'(almost_full[2]), 32'(i + 1 >= 14));
            check_eq($sformatf("ch2_full_%0d", i + 1), 32'(full[2]), 32'(i + 1 == 16));
        end
        check_eq("ch2_no_ovf_yet", 32'(ovf_err), 32'd0);
        wr_data = 8'hEE;
        step();
        idle();
        check_eq("ch2_ovf", 32'(ovf_err), 32'd1);
        check_eq("ch2_cnt16", cnt_of(2), 32'd16);
        check_eq("ch0_cnt0", cnt_of(0), 32'd0);
        check_eq("ch1_cnt0", cnt_of(1), 32'd0);
        check_eq("ch3_cnt0", cnt_of(3), 32'd0);
        clr_err = 1'b1;
        step();
        idle();
        check_eq("ovf_cleared", 32'(ovf_err), 32'd0);

        // Underflow on ch0, clear, and set-wins-over-clear
        rd_en = 1'b1; rd_ch = 2'd0;
        step();
        idle();
        check_eq("udf_valid", 32'(rd_valid), 32'd0);
        check_eq("udf_hold", 32'(rd_data), 32'h33);
        check_eq("udf_set", 32'(udf_err), 32'd1);
        clr_err = 1'b1;
        step();
        check_eq("udf_cleared", 32'(udf_err), 32'd0);
        rd_en = 1'b1;
        step();
        idle();
        check_eq("udf_set_wins", 32'(udf_err), 32'd1);
        clr_err = 1'b1;
        step();
        idle();

        // Same-cycle write/read on a full channel
        wr_en = 1'b1; wr_ch = 2'd3;
        for (int i = 0; i < 16; i++) begin
            wr_data = 8'(8'hC0 + i);
            step();
        end
        check_eq("ch3_full", 32'(full[3]), 32'd1);
        wr_data = 8'hFF; rd_en = 1'b1; rd_ch = 2'd3;
        step();
        idle();
        check_eq("fullrw_valid", 32'(rd_valid), 32'd1);
        check_eq("fullrw_data", 32'(rd_data), 32'hC0);
        check_eq("fullrw_cnt", cnt_of(3), 32'd15);
        check_eq("fullrw_ovf", 32'(ovf_err), 32'd1);
        rd_en = 1'b1; rd_ch = 2'd3;
        for (int i = 1; i < 16; i++) begin
            step();
            check_eq($sformatf("ch3_drain_%0d", i), 32'(rd_data), 32'(8'hC0 + i));
        end
        idle();
        step();
        check_eq("ch3_drained", 32'(empty[3]), 32'd1);

        // Same-cycle write/read on an empty channel
        clr_err = 1'b1;
        step();
        idle();
        wr_en = 1'b1; wr_ch = 2'd3; wr_data = 8'h77; rd_en = 1'b1; rd_ch = 2'd3;
        step();
        idle();
        check_eq("emptyrw_valid", 32'(rd_valid), 32'd0);
        check_eq("emptyrw_udf", 32'(udf_err), 32'd1);
        check_eq("emptyrw_ovf", 32'(ovf_err), 32'd0);
        check_eq("emptyrw_cnt", cnt_of(3), 32'd1);
        rd_en = 1'b1; rd_ch = 2'd3;
        step();
        idle();
        check_eq("emptyrw_data", 32'(rd_data), 32'h77);
        clr_err = 1'b1;
        step();
        idle();

        // Pointer wrap on ch1 at constant occupancy 3
        wr_en = 1'b1; wr_ch = 2'd1;
        for (int i = 0; i < 3; i++) begin
            wr_data = 8'(8'h50 + i);
            step();
        end
        rd_en = 1'b1; rd_ch = 2'd1;
        for (int k = 0; k < 40; k++) begin
            wr_data = 8'(8'h53 + k);
            step();
            check_eq($sformatf("wrap_data_%0d", k), 32'(rd_data), 32'(8'h50 + k));
            check_eq($sformatf("wrap_cnt_%0d", k), cnt_of(1), 32'd3);
        end
        idle();
        wr_en = 1'b1; wr_ch = 2'd1;
        wr_data = 8'h90; step();
        wr_data = 8'h91; step();
        idle();
        check_eq("pre_rst_cnt5", cnt_of(1), 32'd5);

        // Asynchronous reset mid-operation
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_state("midrst");
        #1;
        rst_n = 1'b1;
        rd_en = 1'b1; rd_ch = 2'd1;
        step();
        idle();
        check_eq("postrst_valid", 32'(rd_valid), 32'd0);
        check_eq("postrst_udf", 32'(udf_err), 32'd1);
        check_eq("postrst_cnt", cnt_of(1), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
